retire_tracker: RTL and testbench
=================================

Name: retire_tracker

Overview:
Simulation-side in-order retire tracker for the 4-stage RV32 core (I/X/M/R).
- Captures PC and instruction word when an instruction validly leaves the X stage (not hazard-stalled).
- Holds them in a small FIFO until that instruction reaches R, then pairs them with the register writeback result.
- Emits one registered commit record per retired instruction, plus a running retire count and sticky ordering-error flags.
- Feeds the trace/log formatter and the bench's pass/fail logic with retirement-accurate data instead of fetch-time data.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2 (X→R distance is 2 stages plus slack).
- AW, 2: pointer width, equal to log2(DEPTH).
- XLEN, 32: PC, instruction and data width.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- x_valid  input  1  instruction leaves X this cycle (inst_v_x & !hazard_x); push.
- x_pc  input  XLEN  PC of the X-stage instruction.
- x_inst  input  32  instruction word of the X-stage instruction.
- r_valid  input  1  instruction retires from R this cycle; pop.
- wb_v  input  1  the retiring instruction writes a register.
- wb_rd  input  5  destination register index.
- wb_data  input  XLEN  writeback value.
- cmt_valid  output  1  commit record valid, one-cycle pulse.
- cmt_pc  output  XLEN  PC of the retired instruction.
- cmt_inst  output  32  instruction word.
- cmt_rd_v  output  1  register write occurred.
- cmt_rd  output  5  destination index; 0 when cmt_rd_v=0.
- cmt_data  output  XLEN  written value; 0 when cmt_rd_v=0.
- cmt_count  output  32  number of records emitted since reset.
- occupancy  output  AW+1  current FIFO fill level.
- err_ovf  output  1  sticky: push while full without a simultaneous pop.
- err_unf  output  1  sticky: pop while empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears read/write pointers and occupancy.
  - Clears all cmt_* outputs, cmt_count, err_ovf and err_unf.
  - FIFO storage is not cleared.
  - If reset is asserted mid-operation, all in-flight entries are discarded immediately.
- FIFO: circular buffer of {pc, inst}. Pointers are AW+1 bits with a wrap bit. Full when MSBs differ and the low bits are equal; empty when the pointers are equal.
- Push (x_valid=1, not full): write at wr_ptr, then wr_ptr+1.
- Pop (r_valid=1, not empty): read at rd_ptr, then rd_ptr+1.
- Simultaneous push and pop:
  - Always allowed, including at full: occupancy unchanged, pointers both advance.
  - When empty, the pushed entry is not bypassed to the pop. The pop is an underflow: err_unf is set, no record is emitted, and the push is still written.
- Overflow: x_valid=1 with full and r_valid=0 drops the push (no pointer change) and sets err_ovf.
- Underflow: r_valid=1 with empty sets err_unf and emits no record; cmt_valid stays 0.
- Sticky flags clear only on reset.
- Commit record, one-cycle latency:
  - A valid pop in cycle N gives cmt_valid=1 in cycle N+1.
  - The record carries the popped pc/inst and the wb_v/wb_rd/wb_data sampled in cycle N.
  - wb_rd=0 with wb_v=1 reports cmt_rd_v=0 (x0 writes are not architectural).
  - cmt_rd and cmt_data are forced to 0 when cmt_rd_v=0.
  - Without a valid pop, cmt_valid=0 and the other cmt_* fields hold their last values.
- cmt_count: increments in the same cycle cmt_valid is asserted (the registered count includes the current record). It wraps modulo 2^32 with no saturation.
- occupancy: always equals wr_ptr − rd_ptr (AW+1 bits); ranges 0..DEPTH.
- Ordering: records are strictly in push order; wrap-around is transparent.

Test Plan:
1. Reset, then 3 pushes (pc 0x200,0x204,0x208), then 3 pops with wb_v=1, rd=5, data 0xA,0xB,0xC → cmt_valid pulses one cycle after each pop with matching pc/inst/data; cmt_count ends at 3; occupancy ends at 0.
2. Fill to DEPTH=4, then push and pop together for 10 cycles (pcs incrementing by 4) → occupancy stays 4; records arrive in order across pointer wrap; err_ovf=0.
3. At full, push with r_valid=0 → err_ovf=1; pushed pc absent from later records; occupancy stays 4.
4. Pop on empty (with or without a simultaneous push) → err_unf=1; no cmt_valid; when pushed, entry remains (occupancy=1).
5. Retire with wb_v=1, wb_rd=0, wb_data=0xDEAD → cmt_rd_v=0, cmt_rd=0, cmt_data=0; cmt_count still increments.
6. Assert reset asynchronously mid-stream with 2 entries queued → occupancy, cmt_valid, cmt_count and error flags are 0 immediately; after release, the next record carries the first post-reset push.

Source files
------------

// File: rtl/retire_tracker.sv
// In-order retire tracker: queues {pc, inst} when an instruction leaves X
// and pairs each entry with its R-stage writeback as a registered commit record.
module retire_tracker #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            x_valid,
  input  logic [XLEN-1:0] x_pc,
  input  logic [31:0]     x_inst,
  input  logic            r_valid,
  input  logic            wb_v,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            cmt_valid,
  output logic [XLEN-1:0] cmt_pc,
  output logic [31:0]     cmt_inst,
  output logic            cmt_rd_v,
  output logic [4:0]      cmt_rd,
  output logic [XLEN-1:0] cmt_data,
  output logic [31:0]     cmt_count,
  output logic [AW:0]     occupancy,
  output logic            err_ovf,
  output logic            err_unf
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            rd_v;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } cmt_t;

  entry_t mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  cmt_t        cmt_q, cmt_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic   full;
  logic   empty;
  logic   push_ok;
  logic   pop_ok;
  logic   rd_nz;
  entry_t head;

  // Pointer-derived status and the handshake qualification.
  always_comb begin
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty   = (wr_ptr_q == rd_ptr_q);
    pop_ok  = r_valid && !empty;
    push_ok = x_valid && (!full || r_valid);
    rd_nz   = wb_v && (wb_rd != 5'd0);
    head    = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next-state for pointers, commit record, count and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cmt_d    = cmt_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    cmt_d.valid = 1'b0;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop_ok) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      cmt_d.valid = 1'b1;
      cmt_d.pc    = head.pc;
      cmt_d.inst  = head.inst;
      cmt_d.rd_v  = rd_nz;
      cmt_d.rd    = rd_nz ? wb_rd : 5'd0;
      cmt_d.data  = rd_nz ? wb_data : '0;
      cnt_d       = cnt_q + 32'd1;
    end

    if (x_valid && full && !r_valid) begin
      ovf_d = 1'b1;
    end

    if (r_valid && empty) begin
      unf_d = 1'b1;
    end
  end

  // Control state; reset discards every queued entry at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cmt_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cmt_q    <= cmt_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Entry storage is left uninitialised; only pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{pc: x_pc, inst: x_inst};
    end
  end

  assign cmt_valid = cmt_q.valid;
  assign cmt_pc    = cmt_q.pc;
  assign cmt_inst  = cmt_q.inst;
  assign cmt_rd_v  = cmt_q.rd_v;
  assign cmt_rd    = cmt_q.rd;
  assign cmt_data  = cmt_q.data;
  assign cmt_count = cnt_q;
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;

endmodule

// File: tb/tb_retire_tracker.sv
// Randomised and directed bench for retire_tracker against a queue model.
// Model: a FIFO queue of {pc, inst} plus the architectural commit rules.
module tb_retire_tracker;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int XLEN  = 32;

  logic            clk;
  logic            reset;
  logic            x_valid;
  logic [XLEN-1:0] x_pc;
  logic [31:0]     x_inst;
  logic            r_valid;
  logic            wb_v;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            cmt_valid;
  logic [XLEN-1:0] cmt_pc;
  logic [31:0]     cmt_inst;
  logic            cmt_rd_v;
  logic [4:0]      cmt_rd;
  logic [XLEN-1:0] cmt_data;
  logic [31:0]     cmt_count;
  logic [AW:0]     occupancy;
  logic            err_ovf;
  logic            err_unf;

  retire_tracker #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .XLEN (XLEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .x_valid  (x_valid),
    .x_pc     (x_pc),
    .x_inst   (x_inst),
    .r_valid  (r_valid),
    .wb_v     (wb_v),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .cmt_valid(cmt_valid),
    .cmt_pc   (cmt_pc),
    .cmt_inst (cmt_inst),
    .cmt_rd_v (cmt_rd_v),
    .cmt_rd   (cmt_rd),
    .cmt_data (cmt_data),
    .cmt_count(cmt_count),
    .occupancy(occupancy),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [63:0] q_m [$];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_rd_v;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int unsigned m_count;
  logic        m_ovf;
  logic        m_unf;
  bit          seen_pc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_m.delete();
    m_valid = 1'b0;
    m_pc    = '0;
    m_inst  = '0;
    m_rd_v  = 1'b0;
    m_rd    = '0;
    m_data  = '0;
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(cmt_valid), 32'(m_valid));
    check({tag, ".pc"}, cmt_pc, m_pc);
    check({tag, ".inst"}, cmt_inst, m_inst);
    check({tag, ".rd_v"}, 32'(cmt_rd_v), 32'(m_rd_v));
    check({tag, ".rd"}, 32'(cmt_rd), 32'(m_rd));
    check({tag, ".data"}, cmt_data, m_data);
    check({tag, ".count"}, cmt_count, m_count);
    check({tag, ".occ"}, 32'(occupancy), 32'(q_m.size()));
    check({tag, ".ovf"}, 32'(err_ovf), 32'(m_ovf));
    check({tag, ".unf"}, 32'(err_unf), 32'(m_unf));
  endtask

  // One clock: drive, let the edge happen, update model, compare.
  task automatic cyc(input string tag, input bit xv, input logic [31:0] pc,
                     input logic [31:0] inst, input bit rv, input bit wv,
                     input logic [4:0] rd, input logic [31:0] data);
    int sz0;
    logic [63:0] e;
    x_valid = xv;
    x_pc    = pc;
    x_inst  = inst;
    r_valid = rv;
    wb_v    = wv;
    wb_rd   = rd;
    wb_data = data;
    @(posedge clk);
    sz0     = q_m.size();
    m_valid = 1'b0;
    if (rv) begin
      if (sz0 == 0) begin
        m_unf = 1'b1;
      end else begin
        e       = q_m.pop_front();
        m_valid = 1'b1;
        m_pc    = e[63:32];
        m_inst  = e[31:0];
        m_rd_v  = wv && (rd != 0);
        m_rd    = m_rd_v ? rd : 5'd0;
        m_data  = m_rd_v ? data : 32'd0;
        m_count = m_count + 1;
      end
    end
    if (xv) begin
      if (sz0 == DEPTH && !rv) m_ovf = 1'b1;
      else q_m.push_back({pc, inst});
    end
    #1;
    check_all(tag);
    if (cmt_valid && cmt_pc == 32'h0000_0DD0) seen_pc = 1'b1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    x_valid = 1'b0;
    r_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    n_cmp   = 0;
    n_bad   = 0;
    seen_pc = 1'b0;
    x_valid = 1'b0;
    x_pc    = '0;
    x_inst  = '0;
    r_valid = 1'b0;
    wb_v    = 1'b0;
    wb_rd   = '0;
    wb_data = '0;
    reset   = 1'b1;
    model_clear();
    #3;
    async_reset("rst0");

    // 1: basic push then pop.
    for (int i = 0; i < 3; i++)
      cyc("t1p", 1, 32'h200 + 32'(4 * i), $urandom, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("t1r", 0, 0, 0, 1, 1, 5'd5, 32'hA + 32'(i));
    idle("t1i");
    check("t1.count3", cmt_count, 32'd3);

    // 2: fill then stream across pointer wrap.
    pc = 32'h400;
    for (int i = 0; i < DEPTH; i++) begin
      cyc("t2f", 1, pc, $urandom, 0, 0, 0, 0);
      pc += 4;
    end
    for (int i = 0; i < 10; i++) begin
      cyc("t2s", 1, pc, $urandom, 1, 1, 5'($urandom_range(1, 31)), $urandom);
      pc += 4;
      check("t2.occ4", 32'(occupancy), 32'd4);
    end

    // 3: overflow at full drops the push.
    cyc("t3o", 1, 32'h0000_0DD0, $urandom, 0, 0, 0, 0);
    check("t3.ovf", 32'(err_ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++)
      cyc("t3d", 0, 0, 0, 1, 1, 5'd7, $urandom);
    check("t3.dropped", 32'(seen_pc), 32'd0);

    // 4: underflow, alone and with a push.
    cyc("t4a", 0, 0, 0, 1, 0, 0, 0);
    cyc("t4b", 1, 32'h800, $urandom, 1, 0, 0, 0);
    check("t4.unf", 32'(err_unf), 32'd1);
    check("t4.occ1", 32'(occupancy), 32'd1);

    // 5: x0 writeback is not architectural.
    cyc("t5", 0, 0, 0, 1, 1, 5'd0, 32'hDEAD);
    check("t5.rdv0", 32'(cmt_rd_v), 32'd0);
    check("t5.data0", cmt_data, 32'd0);

    // 6: async reset with two entries queued.
    cyc("t6a", 1, 32'h900, $urandom, 0, 0, 0, 0);
    cyc("t6b", 1, 32'h904, $urandom, 0, 0, 0, 0);
    async_reset("t6r");
    cyc("t6c", 1, 32'hA00, $urandom, 0, 0, 0, 0);
    cyc("t6d", 0, 0, 0, 1, 1, 5'd3, 32'h55);
    check("t6.pc", cmt_pc, 32'hA00);

    // Random traffic with occasional resets.
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      bit xv, rv;
      xv = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) != 0);
      cyc("rnd", xv, pc, $urandom, rv, 1'($urandom),
          5'($urandom), $urandom);
      if (xv) pc += 4;
      if (i % 150 == 149) async_reset("rndrst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
